// File: rtl/product_serializer.sv
// Product-word serializer: buffers finished multiplier products in a small word FIFO
// and streams each one out LS byte first on an 8-bit valid/ready beat bus.
module product_serializer #(
    parameter int DATA_W = 16,
    parameter int BYTE_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              aclr_n,
    input  logic              clk_ena,
    input  logic              sclr_n,
    input  logic              load,
    input  logic [DATA_W-1:0] datain,
    output logic              load_ready,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              last,
    output logic              overflow
);

    localparam int NB = DATA_W / BYTE_W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [IW-1:0]   byte_idx_q, byte_idx_d;
    logic            overflow_q, overflow_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic                         full;
    logic                         push;
    logic                         beat;
    logic                         pop_word;
    logic                         idx_at_last;
    logic [NB-1:0][BYTE_W-1:0]    head_bytes;

    assign full        = (count_q == CW'(DEPTH));
    assign load_ready  = !full;
    assign byte_valid  = (state_q == SEND);
    assign idx_at_last = (byte_idx_q == IW'(NB - 1));
    assign last        = byte_valid && idx_at_last;
    assign head_bytes  = mem_q[rd_ptr_q];
    assign byte_out    = byte_valid ? head_bytes[byte_idx_q] : '0;
    assign overflow    = overflow_q;

    assign push     = clk_ena && sclr_n && load && load_ready;
    assign beat     = clk_ena && sclr_n && byte_valid && byte_ready;
    assign pop_word = beat && idx_at_last;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            byte_idx_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= datain;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        overflow_d = overflow_q;

        if (clk_ena) begin
            if (!sclr_n) begin
                state_d    = IDLE;
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                count_d    = '0;
                byte_idx_d = '0;
                overflow_d = 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (load && !load_ready) begin
                    overflow_d = 1'b1;
                end
                if (beat) begin
                    if (idx_at_last) begin
                        byte_idx_d = '0;
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
                count_d = count_q + CW'(push) - CW'(pop_word);
                // SEND exactly while a word is held, so consecutive words stream without a bubble.
                state_d = (count_d != '0) ? SEND : IDLE;
            end
        end
    end

endmodule

// File: tb/tb_product_serializer.sv
// Randomized and directed bench for product_serializer, checked by a word/beat
// scoreboard model sampled on the falling clock edge.
module tb_product_serializer;

    localparam int DATA_W = 16;
    localparam int BYTE_W = 8;
    localparam int DEPTH  = 2;
    localparam int NB     = DATA_W / BYTE_W;

    logic              clk = 1'b0;
    logic              aclr_n = 1'b0;
    logic              clk_ena = 1'b1;
    logic              sclr_n = 1'b1;
    logic              load = 1'b0;
    logic [DATA_W-1:0] datain = '0;
    logic              load_ready;
    logic [BYTE_W-1:0] byte_out;
    logic              byte_valid;
    logic              byte_ready = 1'b0;
    logic              last;
    logic              overflow;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: words held in the FIFO, the beats still owed, and the sticky flag.
    logic [BYTE_W:0] expQ [$];
    int              wordCount = 0;
    logic            modelOvf  = 1'b0;

    product_serializer #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .aclr_n     (aclr_n),
        .clk_ena    (clk_ena),
        .sclr_n     (sclr_n),
        .load       (load),
        .datain     (datain),
        .load_ready (load_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .last       (last),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [DATA_W-1:0] d, input logic rdy,
                                 input logic ena, input logic sclr);
        @(posedge clk);
        #1;
        load       = ld;
        datain     = d;
        byte_ready = rdy;
        clk_ena    = ena;
        sclr_n     = sclr;
    endtask

    task automatic idleCycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, rdy, 1'b1, 1'b1);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (wordCount != 0 && budget < 50) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
            budget++;
        end
        idleCycles(2, 1'b1);
        checkOutput("drain_complete", (wordCount == 0 && expQ.size() == 0), 1);
    endtask

    always @(negedge aclr_n) begin
        expQ.delete();
        wordCount = 0;
        modelOvf  = 1'b0;
    end

    // Monitor: compare what the DUT presents against the model, then advance the model
    // by the transfers the coming rising edge will perform.
    always @(negedge clk) begin
        if (aclr_n) begin
            checkOutput("byte_valid", byte_valid, (wordCount > 0));
            checkOutput("load_ready", load_ready, (wordCount < DEPTH));
            checkOutput("overflow", overflow, modelOvf);
            if (byte_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", 1, 0);
                end else begin
                    checkOutput("byte_out", byte_out, expQ[0][BYTE_W-1:0]);
                    checkOutput("last", last, expQ[0][BYTE_W]);
                end
            end

            if (clk_ena) begin
                if (!sclr_n) begin
                    expQ.delete();
                    wordCount = 0;
                    modelOvf  = 1'b0;
                end else begin
                    int pushed;
                    int popped;
                    logic [BYTE_W:0] b;
                    pushed = 0;
                    popped = 0;
                    if (wordCount > 0 && byte_ready && expQ.size() > 0) begin
                        b = expQ.pop_front();
                        if (b[BYTE_W]) popped = 1;
                    end
                    if (load) begin
                        if (wordCount < DEPTH) begin
                            for (int k = 0; k < NB; k++)
                                expQ.push_back({(k == NB - 1), datain[k*BYTE_W +: BYTE_W]});
                            pushed = 1;
                        end else begin
                            modelOvf = 1'b1;
                        end
                    end
                    wordCount = wordCount + pushed - popped;
                end
            end
        end
    end

    initial begin
        #3;
        checkOutput("rst_byte_valid", byte_valid, 0);
        checkOutput("rst_byte_out", byte_out, 0);
        checkOutput("rst_last", last, 0);
        checkOutput("rst_load_ready", load_ready, 1);
        checkOutput("rst_overflow", overflow, 0);
        #9 aclr_n = 1'b1;

        // Single word, full-rate drain.
        applyStimulus(1'b1, 16'h1234, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        checkOutput("t1_valid_after_load", byte_valid, 1);
        checkOutput("t1_first_byte", byte_out, 8'h34);
        checkOutput("t1_first_last", last, 0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        checkOutput("t1_second_byte", byte_out, 8'h12);
        checkOutput("t1_second_last", last, 1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        checkOutput("t1_idle_after", byte_valid, 0);

        // Fill, overflow, then drain back-to-back.
        applyStimulus(1'b1, 16'hABCD, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h5678, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h9999, 1'b0, 1'b1, 1'b1);
        checkOutput("t2_full", load_ready, 0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        checkOutput("t2_overflow", overflow, 1);
        drain();

        // Backpressure pattern.
        applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checkOutput("t3_hold_byte", byte_out, 8'hBE);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        drain();

        // Clock-enable freeze mid-word.
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h7777, 1'b1, 1'b0, 1'b1);
        checkOutput("t4_after_first", byte_out, 8'h12);
        applyStimulus(1'b1, 16'h7777, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h7777, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        checkOutput("t4_frozen_byte", byte_out, 8'h12);
        checkOutput("t4_frozen_last", last, 1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        checkOutput("t4_done", byte_valid, 0);

        // Flush: ignored while disabled, effective when enabled.
        applyStimulus(1'b1, 16'h1111, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h2222, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h3333, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_ovf_set", overflow, 1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_disabled_flush_ovf", overflow, 1);
        checkOutput("t5_disabled_flush_valid", byte_valid, 1);
        applyStimulus(1'b1, 16'h4444, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checkOutput("t5_flush_valid", byte_valid, 0);
        checkOutput("t5_flush_ready", load_ready, 1);
        checkOutput("t5_flush_ovf", overflow, 0);

        // Asynchronous reset mid-beat.
        applyStimulus(1'b1, 16'h1234, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        #3 aclr_n = 1'b0;
        #1;
        checkOutput("t6_async_valid", byte_valid, 0);
        checkOutput("t6_async_byte", byte_out, 0);
        checkOutput("t6_async_last", last, 0);
        checkOutput("t6_async_ready", load_ready, 1);
        @(posedge clk);
        #2 aclr_n = 1'b1;
        applyStimulus(1'b1, 16'h00FF, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        checkOutput("t6_post_byte", byte_out, 8'hFF);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 1) == 1), DATA_W'($urandom),
                          ($urandom_range(0, 4) < 3), ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 39) != 0));
        end
        drain();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
